// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the credit-regulated NoC send-port arbiter.
// Widths here describe the default configuration; parameterised modules derive their own.
package noc_arb_pkg;

   localparam int DEF_ADDRESS_WIDTH    = 4;
   localparam int DEF_VC_ADDRESS_WIDTH = 2;
   localparam int DEF_NUM_CREDITS      = 8;

   function automatic int credit_w(input int n);
      return $clog2(n + 1);
   endfunction

   typedef logic [credit_w(DEF_NUM_CREDITS)-1:0] credit_t;
   typedef logic [DEF_ADDRESS_WIDTH-1:0]         dest_t;
   typedef logic [DEF_VC_ADDRESS_WIDTH-1:0]      vc_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: rotate eligible by rr_ptr, take the lowest set bit,
// rotate back. Output is one-hot, or zero when nothing is eligible.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [PW-1:0]      rr_ptr,
   output logic [NUM_REQ-1:0] grant
);

   logic [NUM_REQ-1:0] rotated;
   logic [NUM_REQ-1:0] rot_grant;

   always_comb begin
      rotated = '0;
      grant   = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         rotated[j] = eligible[(j + int'(rr_ptr)) % NUM_REQ];
      end
      // Two's-complement trick isolates the lowest set bit, i.e. first requester at/after rr_ptr.
      rot_grant = rotated & (~rotated + NUM_REQ'(1));
      for (int j = 0; j < NUM_REQ; j++) begin
         grant[(j + int'(rr_ptr)) % NUM_REQ] = rot_grant[j];
      end
   end

endmodule

// File: rtl/noc_credit_arbiter.sv
// Shares one NoC send port among NUM_REQ masters, admitting a flit only when its destination
// holds a credit; returned replies re-credit the destination counter.
module noc_credit_arbiter
   import noc_arb_pkg::*;
#(
   parameter int NUM_REQ          = 4,
   parameter int ADDRESS_WIDTH    = 4,
   parameter int VC_ADDRESS_WIDTH = 2,
   parameter int WIDTH_DATA       = 36,
   parameter int NUM_CREDITS      = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_REQ-1:0]                   req_valid,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  logic [NUM_REQ*WIDTH_DATA-1:0]        req_data,
   input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]     req_dest,
   input  logic [NUM_REQ*VC_ADDRESS_WIDTH-1:0]  req_vc,
   output logic                                 out_valid,
   output logic [WIDTH_DATA-1:0]                out_data,
   output logic [ADDRESS_WIDTH-1:0]             out_dest,
   output logic [VC_ADDRESS_WIDTH-1:0]          out_vc,
   input  logic                                 out_ready,
   input  logic                                 credit_valid,
   input  logic [ADDRESS_WIDTH-1:0]             credit_dest,
   output logic                                 credit_err
);

   localparam int NUM_DEST = 2 ** ADDRESS_WIDTH;
   localparam int CW       = credit_w(NUM_CREDITS);
   localparam int PW       = $clog2(NUM_REQ);
   localparam logic [CW-1:0] FULL = CW'(NUM_CREDITS);

   logic [CW-1:0]               credit_q [NUM_DEST];
   logic [PW-1:0]               rr_ptr_q;
   logic [PW-1:0]               next_ptr;
   logic [NUM_REQ-1:0]          eligible;
   logic [NUM_REQ-1:0]          arb_grant;
   logic [NUM_REQ-1:0]          grant;
   logic                        can_issue;
   logic                        any_grant;
   logic [WIDTH_DATA-1:0]       sel_data;
   logic [ADDRESS_WIDTH-1:0]    sel_dest;
   logic [VC_ADDRESS_WIDTH-1:0] sel_vc;
   logic [PW-1:0]               sel_idx;
   logic [NUM_DEST-1:0]         dec_vec;
   logic [NUM_DEST-1:0]         inc_vec;
   logic                        err_hit;

   // Handshake: a flit moves on any cycle where valid and ready are both high. req_ready is a
   // combinational grant; out_valid/out_* are registered and hold stable until out_ready.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid[i] &&
                       (credit_q[req_dest[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]] != '0);
      end
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_rr_arbiter (
      .eligible (eligible),
      .rr_ptr   (rr_ptr_q),
      .grant    (arb_grant)
   );

   assign can_issue = ~rst & (~out_valid | out_ready);
   assign grant     = can_issue ? arb_grant : '0;
   assign req_ready = grant;
   assign any_grant = |grant;

   always_comb begin
      sel_data = '0;
      sel_dest = '0;
      sel_vc   = '0;
      sel_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_data = req_data[i*WIDTH_DATA +: WIDTH_DATA];
            sel_dest = req_dest[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            sel_vc   = req_vc[i*VC_ADDRESS_WIDTH +: VC_ADDRESS_WIDTH];
            sel_idx  = PW'(i);
         end
      end
   end

   assign next_ptr = (sel_idx == PW'(NUM_REQ - 1)) ? '0 : sel_idx + PW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_dest  <= '0;
         out_vc    <= '0;
         rr_ptr_q  <= '0;
      end else if (any_grant) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_dest  <= sel_dest;
         out_vc    <= sel_vc;
         rr_ptr_q  <= next_ptr;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // A debit and a return hitting the same destination cancel, so neither saturation nor err applies.
   always_comb begin
      err_hit = 1'b0;
      for (int d = 0; d < NUM_DEST; d++) begin
         dec_vec[d] = any_grant && (sel_dest == ADDRESS_WIDTH'(d));
         inc_vec[d] = credit_valid && (credit_dest == ADDRESS_WIDTH'(d));
         if (inc_vec[d] && !dec_vec[d] && (credit_q[d] == FULL)) err_hit = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credit_err <= 1'b0;
         for (int d = 0; d < NUM_DEST; d++) credit_q[d] <= FULL;
      end else begin
         if (err_hit) credit_err <= 1'b1;
         for (int d = 0; d < NUM_DEST; d++) begin
            if (inc_vec[d] && !dec_vec[d] && (credit_q[d] != FULL)) begin
               credit_q[d] <= credit_q[d] + CW'(1);
            end else if (dec_vec[d] && !inc_vec[d]) begin
               credit_q[d] <= credit_q[d] - CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_noc_credit_arbiter.sv
// Scenario bench for noc_credit_arbiter with a cycle-level reference model built from
// per-destination credit counts and a round-robin search.
module tb_noc_credit_arbiter;

   localparam int NR = 4;
   localparam int AW = 4;
   localparam int VW = 2;
   localparam int WD = 36;
   localparam int NC = 4;
   localparam int ND = 2 ** AW;

   logic             clk;
   logic             rst;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR*WD-1:0] req_data;
   logic [NR*AW-1:0] req_dest;
   logic [NR*VW-1:0] req_vc;
   logic             out_valid;
   logic [WD-1:0]    out_data;
   logic [AW-1:0]    out_dest;
   logic [VW-1:0]    out_vc;
   logic             out_ready;
   logic             credit_valid;
   logic [AW-1:0]    credit_dest;
   logic             credit_err;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int          m_cred [ND];
   int          m_rr;
   logic        m_ov;
   logic [WD-1:0] m_od;
   logic [AW-1:0] m_odest;
   logic [VW-1:0] m_ovc;
   logic        m_err;

   noc_credit_arbiter #(
      .NUM_REQ          (NR),
      .ADDRESS_WIDTH    (AW),
      .VC_ADDRESS_WIDTH (VW),
      .WIDTH_DATA       (WD),
      .NUM_CREDITS      (NC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_data     (req_data),
      .req_dest     (req_dest),
      .req_vc       (req_vc),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_dest     (out_dest),
      .out_vc       (out_vc),
      .out_ready    (out_ready),
      .credit_valid (credit_valid),
      .credit_dest  (credit_dest),
      .credit_err   (credit_err)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- model ----------------
   function automatic int model_pick();
      int i;
      if (rst) return -1;
      if (m_ov && !out_ready) return -1;
      for (int k = 0; k < NR; k++) begin
         i = (m_rr + k) % NR;
         if (req_valid[i] && m_cred[int'(req_dest[i*AW +: AW])] > 0) return i;
      end
      return -1;
   endfunction

   function automatic logic [NR-1:0] onehot(input int g);
      logic [NR-1:0] v;
      v = '0;
      if (g >= 0) v[g] = 1'b1;
      return v;
   endfunction

   task automatic model_clock(input int g);
      int gd;
      int cd;
      if (rst) begin
         for (int d = 0; d < ND; d++) m_cred[d] = NC;
         m_rr = 0; m_ov = 1'b0; m_od = '0; m_odest = '0; m_ovc = '0; m_err = 1'b0;
         return;
      end
      gd = -1;
      if (g >= 0) begin
         gd      = int'(req_dest[g*AW +: AW]);
         m_od    = req_data[g*WD +: WD];
         m_odest = req_dest[g*AW +: AW];
         m_ovc   = req_vc[g*VW +: VW];
         m_ov    = 1'b1;
         m_rr    = (g + 1) % NR;
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      cd = credit_valid ? int'(credit_dest) : -1;
      if (gd >= 0 && gd != cd) m_cred[gd] = m_cred[gd] - 1;
      if (cd >= 0 && cd != gd) begin
         if (m_cred[cd] == NC) m_err = 1'b1;
         else m_cred[cd] = m_cred[cd] + 1;
      end
   endtask

   function automatic string dut_s();
      return $sformatf("v=%b d=%h dst=%h vc=%h err=%b", out_valid, out_data, out_dest, out_vc, credit_err);
   endfunction

   function automatic string mdl_s();
      return $sformatf("v=%b d=%h dst=%h vc=%h err=%b", m_ov, m_od, m_odest, m_ovc, m_err);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_req(input int i, input logic v, input int dest, input int vc);
      req_valid[i]          = v;
      req_dest[i*AW +: AW]  = AW'(dest);
      req_vc[i*VW +: VW]    = VW'(vc);
      req_data[i*WD +: WD]  = {$urandom, $urandom};
   endtask

   task automatic clear_inputs();
      req_valid    = '0;
      req_data     = '0;
      req_dest     = '0;
      req_vc       = '0;
      out_ready    = 1'b1;
      credit_valid = 1'b0;
      credit_dest  = '0;
   endtask

   // One cycle: called at posedge+1 with inputs set; samples req_ready, advances clock and model.
   task automatic tick(output int g, output logic [NR-1:0] rdy);
      #1;
      g   = model_pick();
      rdy = req_ready;
      @(posedge clk);
      model_clock(g);
      #1;
   endtask

   task automatic do_reset();
      int g;
      logic [NR-1:0] rdy;
      clear_inputs();
      rst = 1'b1;
      tick(g, rdy);
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int g;
      logic [NR-1:0] rdy;
      clear_inputs();
      rst = 1'b1;
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, $urandom_range(0, ND-1), $urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
         tick(g, rdy);
         n_tests++;
         if (rdy !== '0) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0", rdy);
         end
         n_tests++;
         if ({out_valid, out_data, out_dest, out_vc, credit_err} !== '0) begin
            n_fail++; $display("FAIL reset_out: got %s want all zero", dut_s());
         end
      end
      rst = 1'b0;
      clear_inputs();
   endtask

   task automatic test_alternate();
      int g;
      logic [NR-1:0] rdy;
      logic [NR-1:0] want;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         set_req(0, 1'b1, 3, 1);
         set_req(1, 1'b1, 5, 2);
         tick(g, rdy);
         want = (k < 8) ? NR'(1) << (k % 2) : '0;
         n_tests++;
         if (rdy !== want || rdy !== onehot(g)) begin
            n_fail++; $display("FAIL alt_ready cyc %0d: got %b want %b", k, rdy, want);
         end
         n_tests++;
         if ({out_valid, out_data, out_dest, out_vc, credit_err} !== {m_ov, m_od, m_odest, m_ovc, m_err}) begin
            n_fail++; $display("FAIL alt_out cyc %0d: got %s want %s", k, dut_s(), mdl_s());
         end
      end
   endtask

   task automatic test_credit_stall();
      int g;
      logic [NR-1:0] rdy;
      logic [NR-1:0] want;
      do_reset();
      set_req(2, 1'b1, 2, 3);
      for (int k = 0; k < 8; k++) begin
         credit_valid = (k == 6);
         credit_dest  = AW'(2);
         tick(g, rdy);
         // return pulsed in cycle 6 only unlocks the grant in cycle 7
         want = (k < 4 || k == 7) ? 4'b0100 : 4'b0000;
         n_tests++;
         if (rdy !== want || rdy !== onehot(g)) begin
            n_fail++; $display("FAIL stall_ready cyc %0d: got %b want %b", k, rdy, want);
         end
         n_tests++;
         if ({out_valid, out_data, out_dest, out_vc, credit_err} !== {m_ov, m_od, m_odest, m_ovc, m_err}) begin
            n_fail++; $display("FAIL stall_out cyc %0d: got %s want %s", k, dut_s(), mdl_s());
         end
      end
      credit_valid = 1'b0;
   endtask

   task automatic test_starve();
      int g;
      logic [NR-1:0] rdy;
      do_reset();
      for (int k = 0; k < NC; k++) begin
         set_req(0, 1'b1, 7, 0);
         tick(g, rdy);
      end
      for (int k = 0; k < 8; k++) begin
         set_req(0, 1'b1, 7, 0);
         set_req(1, 1'b1, 1, 1);
         credit_valid = (k > 0);
         credit_dest  = AW'(1);
         tick(g, rdy);
         n_tests++;
         if (rdy !== 4'b0010 || rdy !== onehot(g)) begin
            n_fail++; $display("FAIL starve_ready cyc %0d: got %b want 0010", k, rdy);
         end
         n_tests++;
         if ({out_valid, out_data, out_dest, out_vc, credit_err} !== {m_ov, m_od, m_odest, m_ovc, m_err}) begin
            n_fail++; $display("FAIL starve_out cyc %0d: got %s want %s", k, dut_s(), mdl_s());
         end
      end
      credit_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      int g;
      logic [NR-1:0] rdy;
      logic [WD+AW+VW:0] snap;
      do_reset();
      set_req(0, 1'b1, 6, 2);
      set_req(1, 1'b1, 8, 3);
      tick(g, rdy);
      snap = {out_valid, out_data, out_dest, out_vc};
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_req(0, 1'b1, 6, 2);
         set_req(1, 1'b1, 8, 3);
         tick(g, rdy);
         n_tests++;
         if (rdy !== '0) begin
            n_fail++; $display("FAIL bp_ready cyc %0d: got %b want 0", k, rdy);
         end
         n_tests++;
         if ({out_valid, out_data, out_dest, out_vc} !== snap || snap[WD+AW+VW] !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold cyc %0d: got %s want held %h", k, dut_s(), snap);
         end
      end
      out_ready = 1'b1;
      tick(g, rdy);
      n_tests++;
      if (rdy !== 4'b0010 || rdy !== onehot(g)) begin
         n_fail++; $display("FAIL bp_release: got %b want 0010", rdy);
      end
      n_tests++;
      if ({out_valid, out_data, out_dest, out_vc, credit_err} !== {m_ov, m_od, m_odest, m_ovc, m_err}) begin
         n_fail++; $display("FAIL bp_out: got %s want %s", dut_s(), mdl_s());
      end
   endtask

   task automatic test_same_cycle_and_err();
      int g;
      logic [NR-1:0] rdy;
      do_reset();
      set_req(3, 1'b1, 4, 1);
      tick(g, rdy);
      set_req(3, 1'b1, 4, 1);
      credit_valid = 1'b1;
      credit_dest  = AW'(4);
      tick(g, rdy);
      credit_valid = 1'b0;
      // dest 4 should now hold NC-1 credits: exactly NC-1 more grants
      for (int k = 0; k < NC + 1; k++) begin
         set_req(3, 1'b1, 4, 1);
         tick(g, rdy);
         n_tests++;
         if (rdy !== ((k < NC - 1) ? 4'b1000 : 4'b0000) || rdy !== onehot(g)) begin
            n_fail++; $display("FAIL same_cycle_ready cyc %0d: got %b", k, rdy);
         end
      end
      req_valid = '0;
      credit_valid = 1'b1;
      credit_dest  = AW'(9);
      tick(g, rdy);
      credit_valid = 1'b0;
      for (int k = 0; k < NC + 2; k++) begin
         set_req(0, 1'b1, 9, 2);
         tick(g, rdy);
         n_tests++;
         if (credit_err !== 1'b1 || rdy !== ((k < NC) ? 4'b0001 : 4'b0000) || rdy !== onehot(g)) begin
            n_fail++; $display("FAIL err_sticky cyc %0d: got err=%b rdy=%b want err=1", k, credit_err, rdy);
         end
      end
      do_reset();
      n_tests++;
      if (credit_err !== 1'b0) begin
         n_fail++; $display("FAIL err_clear: got %b want 0", credit_err);
      end
   endtask

   task automatic test_reset_mid();
      int g;
      logic [NR-1:0] rdy;
      do_reset();
      for (int k = 0; k < NC; k++) begin
         set_req(0, 1'b1, 10, 0);
         tick(g, rdy);
      end
      out_ready = 1'b0;
      rst = 1'b1;
      tick(g, rdy);
      rst = 1'b0;
      out_ready = 1'b1;
      n_tests++;
      if (out_valid !== 1'b0 || credit_err !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_out: got %s want v=0 err=0", dut_s());
      end
      for (int k = 0; k < NC + 1; k++) begin
         for (int i = 0; i < NR; i++) set_req(i, 1'b1, 10, i);
         tick(g, rdy);
         n_tests++;
         if (rdy !== ((k < NC) ? NR'(1) << k : '0) || rdy !== onehot(g)) begin
            n_fail++; $display("FAIL rst_mid_grant cyc %0d: got %b", k, rdy);
         end
      end
   endtask

   task automatic test_random();
      int g;
      int d;
      logic [NR-1:0] rdy;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < NR; i++) set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
         out_ready    = ($urandom_range(0, 3) != 0);
         d            = $urandom_range(0, 3);
         credit_dest  = AW'(d);
         credit_valid = (m_cred[d] < NC) && ($urandom_range(0, 1) == 1);
         tick(g, rdy);
         n_tests++;
         if (rdy !== onehot(g)) begin
            n_fail++; $display("FAIL rand_ready cyc %0d: got %b want %b", k, rdy, onehot(g));
         end
         n_tests++;
         if ({out_valid, out_data, out_dest, out_vc, credit_err} !== {m_ov, m_od, m_odest, m_ovc, m_err}) begin
            n_fail++; $display("FAIL rand_out cyc %0d: got %s want %s", k, dut_s(), mdl_s());
         end
      end
      clear_inputs();
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      clear_inputs();
      rst = 1'b1;
      m_rr = 0; m_ov = 1'b0; m_od = '0; m_odest = '0; m_ovc = '0; m_err = 1'b0;
      for (int d = 0; d < ND; d++) m_cred[d] = NC;
      @(posedge clk);
      #1;
      test_reset();
      test_alternate();
      test_credit_stall();
      test_starve();
      test_backpressure();
      test_same_cycle_and_err();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
